fpu_norm_round_pack: RTL and testbench
======================================

// Module: fpu_norm_round_pack
// PURPOSE
//  Back end of the FP add/sub datapath. Takes the raw significand sum that the aligner/adder builds from
//  the swapped (big/small) operands, and restores the result sign from a_is_big_mag. It then normalizes,
//  rounds (RNE) and packs an IEEE-754 single. Two-stage valid/ready pipeline between adder and result bus.
// PARAMETERS
//  SIG_W    24           significand width incl. hidden bit
//  SUM_W    SIG_W+4      sum width: {carry, SIG_W sig bits, guard, round, sticky}
// PORTS
//  clk            in   1      single clock, rising edge
//  rst_n          in   1      asynchronous, active-low reset
//  in_valid       in   1      input beat valid
//  in_ready       out  1      stage 1 can accept
//  sum_sig        in   SUM_W  raw sum; hidden-bit position = bit SUM_W-2
//  exp_big        in   8      biased exponent of larger-magnitude operand
//  sign_a         in   1      sign of A
//  sign_b_eff     in   1      sign of B after op inversion (sub flips it)
//  a_is_big_mag   in   1      from swap stage: 1 = A is the larger magnitude
//  in_special     in   1      NaN/Inf/bypass result already resolved upstream
//  special_val    in   32     packed bypass result
//  out_valid      out  1      result valid
//  out_ready      in   1      downstream accepts
//  result         out  32     packed IEEE-754 single
//  flag_ovf/flag_unf/flag_inx  out 1 each  overflow / underflow (tiny & inexact) / inexact for this result
// BEHAVIOUR
//  - Reset: all valid regs 0; out_valid=0, result=0, all flags=0; in-flight beats are discarded.
//  - Handshake: a beat transfers on valid&ready. in_ready = !s1_v | s2_adv. s2_adv = !out_valid | out_ready.
//    Full throughput, latency 2 cycles. Data holds stable while out_valid & !out_ready.
//  - Sign: a_is_big_mag ? sign_a : sign_b_eff.
//  - S1 normalize:
//    - carry=1: shift right 1, exp+1, shifted-out bit ORs into sticky.
//    - Else: LZC over bits [SUM_W-2:0]; shift left k, exp-k.
//    - Underflow clamp: if exp_big-k < 1, shift limited to exp_big-1 and the result is subnormal (exp field 0).
//    - sum_sig==0: exact zero. Sign is sign_a & sign_b_eff (RNE rule: +0 unless both negative); exp 0.
//  - S2 round (RNE): inc = G & (R | S | lsb). inexact = G|R|S.
//    - Mantissa carry-out after inc: exp+1, mantissa=0.
//    - exp >= 255: result = {sign, 8'hFF, 23'h0}; flag_ovf=1, flag_inx=1.
//    - flag_unf = subnormal/zero-from-tiny & inexact.
//  - in_special: special_val passes through both stages unchanged; all flags 0.
// CONFIGURATION
//  FPU_PACK_STICKY_FLAGS_EN
//  - Defined: adds ports flag_clr (in 1) and sticky_flags (out 3, {ovf, unf, inx}).
//    The register ORs each flag on an out_valid&out_ready transfer and clears to 0 on flag_clr or reset.
//    If a clear and a set occur in the same cycle, the set wins.
//  - Undefined: these ports and the register are absent; per-result flags only.
// STRUCTURE
//  - fpu_pkg: SIG_W, EXP_W=8, EXP_BIAS=127, EXP_MAX=8'hFF, typedef fp32_t {sign, exp, man}.
//  - fpu_pkg: typedef s1_payload_t (norm sig, exp, sign, GRS, special, special_val).
//  - Sub-module fpu_lzc #(.W(SUM_W-1)): combinational leading-zero counter, outputs count and all-zero.
//  - Registers live only in this module: the two pipeline stages.
// TESTING
//  - Carry: sum_sig=28'h8000000, exp_big=127, a_is_big_mag=1, sign_a=0 -> result 32'h40000000 two cycles later; no flags.
//  - Cancellation: sum_sig=28'h0000008, exp_big=127 -> k=23, result 32'h34000000; no flags.
//  - Exact zero: sum_sig=0, sign_a=0, sign_b_eff=1 -> 32'h00000000; sign_a=sign_b_eff=1 -> 32'h80000000.
//  - RNE tie with round-up and carry: sum_sig={1'b0,24'hFFFFFF,3'b100}, exp_big=127 -> 32'h40000000, flag_inx=1.
//    Same with {..,24'hFFFFFE,3'b100} -> 32'h3FFFFFFE (tie to even), flag_inx=1.
//  - Overflow: sum_sig=28'h8000000, exp_big=254 -> 32'h7F800000, flag_ovf=1, flag_inx=1.
//  - Backpressure + reset: hold out_ready=0 and push 3 beats -> in_ready=0 after 2 accepted; release -> outputs in order, none lost.
//    Assert rst_n=0 mid-stream -> out_valid=0 immediately, no stale beat after release.
//    With FPU_PACK_STICKY_FLAGS_EN: sticky_flags accumulate and clear on flag_clr.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared constants and types for the FP add/sub back end (normalize, round, pack).
// Optional sticky-flag register in the top is enabled by FPU_PACK_STICKY_FLAGS_EN.
package fpu_pkg;

   localparam int SIG_W    = 24;
   localparam int SUM_W    = SIG_W + 4;
   localparam int MAN_W    = SIG_W - 1;
   localparam int EXP_W    = 8;
   localparam int EXP_BIAS = 127;
   localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
   localparam int LZC_W    = $clog2(SUM_W);

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] man;
   } fp32_t;

   // Exponent carries one extra bit so a carry out of exponent 254 is not lost
   typedef struct packed {
      logic [SIG_W-1:0] sig;
      logic [EXP_W:0]   exp;
      logic             sign;
      logic [2:0]       grs;
      logic             special;
      logic [31:0]      specialVal;
   } s1_payload_t;

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter; count equals W when the input is all zero.
module fpu_lzc #(
   parameter int W  = 27,
   parameter int CW = $clog2(W + 1)
) (
   input  logic [W-1:0]  value_i,
   output logic [CW-1:0] count_o,
   output logic          allZero_o
);

   // Highest set bit wins because later loop iterations override earlier ones
   always_comb begin
      count_o = CW'(W);
      for (int i = 0; i < W; i++) begin
         if (value_i[i]) begin
            count_o = CW'(W - 1 - i);
         end
      end
   end

   assign allZero_o = ~|value_i;

endmodule

// File: rtl/fpu_norm_round_pack.sv
// Normalize, RNE-round and pack the adder sum into an IEEE-754 single over two valid/ready stages.
// Define FPU_PACK_STICKY_FLAGS_EN to add flag_clr / sticky_flags accumulated exception flags.
module fpu_norm_round_pack
   import fpu_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SUM_W-1:0] sum_sig,
   input  logic [EXP_W-1:0] exp_big,
   input  logic             sign_a,
   input  logic             sign_b_eff,
   input  logic             a_is_big_mag,
   input  logic             in_special,
   input  logic [31:0]      special_val,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      result,
   output logic             flag_ovf,
   output logic             flag_unf,
   output logic             flag_inx
`ifdef FPU_PACK_STICKY_FLAGS_EN
   ,
   input  logic             flag_clr,
   output logic [2:0]       sticky_flags
`endif
);

   logic              s1Valid_q;
   s1_payload_t       s1Payload_q, s1Payload_d;
   logic              outValid_q;
   fp32_t             result_q, resultD;
   logic [2:0]        flags_q, flagsD;
   logic              s2Adv;

   logic [SUM_W-2:0]  lowBits, shifted;
   logic [LZC_W-1:0]  lzCount, shamt, clampShift;
   logic              lzAllZero, clamp;

   logic              inc, inexact, tiny;
   logic [SIG_W:0]    sigRnd;
   logic [EXP_W:0]    expRnd;

   assign s2Adv    = !outValid_q | out_ready;
   assign in_ready = !s1Valid_q | s2Adv;

   assign lowBits = sum_sig[SUM_W-2:0];

   fpu_lzc #(.W(SUM_W - 1)) uLzc (
      .value_i   (lowBits),
      .count_o   (lzCount),
      .allZero_o (lzAllZero)
   );

   // Stage 1: normalize. When the left shift would push the exponent below 1,
   // the shift stops at exp_big-1 and the value is encoded as a subnormal.
   always_comb begin
      clamp       = ({3'b000, lzCount} >= exp_big);
      clampShift  = exp_big[LZC_W-1:0] - LZC_W'(1);
      shamt       = clamp ? ((exp_big == '0) ? '0 : clampShift) : lzCount;
      shifted     = lowBits << shamt;
      s1Payload_d            = '0;
      s1Payload_d.sign       = a_is_big_mag ? sign_a : sign_b_eff;
      s1Payload_d.special    = in_special;
      s1Payload_d.specialVal = special_val;
      if (!in_special) begin
         if (sum_sig[SUM_W-1]) begin
            s1Payload_d.sig = sum_sig[SUM_W-1:4];
            s1Payload_d.grs = {sum_sig[3], sum_sig[2], |sum_sig[1:0]};
            s1Payload_d.exp = {1'b0, exp_big} + 9'd1;
         end else if (lzAllZero) begin
            s1Payload_d.sign = sign_a & sign_b_eff;
         end else begin
            s1Payload_d.sig = shifted[SUM_W-2:3];
            s1Payload_d.grs = shifted[2:0];
            s1Payload_d.exp = clamp ? '0 : ({1'b0, exp_big} - {4'b0000, lzCount});
         end
      end
   end

   // Stage 2: round to nearest even. A subnormal that rounds up into the hidden
   // bit becomes the smallest normal, so its exponent field moves from 0 to 1.
   always_comb begin
      inexact = |s1Payload_q.grs;
      inc     = s1Payload_q.grs[2] & (s1Payload_q.grs[1] | s1Payload_q.grs[0] | s1Payload_q.sig[0]);
      sigRnd  = {1'b0, s1Payload_q.sig} + {{SIG_W{1'b0}}, inc};
      tiny    = (s1Payload_q.exp == '0);
      expRnd  = s1Payload_q.exp + {{EXP_W{1'b0}}, sigRnd[SIG_W]}
                + {{EXP_W{1'b0}}, tiny & sigRnd[SIG_W-1]};
      resultD.sign = s1Payload_q.sign;
      resultD.exp  = expRnd[EXP_W-1:0];
      resultD.man  = sigRnd[MAN_W-1:0];
      flagsD       = {1'b0, tiny & inexact, inexact};
      if (s1Payload_q.special) begin
         resultD = s1Payload_q.specialVal;
         flagsD  = 3'b000;
      end else if (expRnd >= {1'b0, EXP_MAX}) begin
         resultD.exp = EXP_MAX;
         resultD.man = '0;
         flagsD      = 3'b101;
      end
   end

   // Pipeline registers; the output stage holds its data while stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1Valid_q   <= 1'b0;
         s1Payload_q <= '0;
         outValid_q  <= 1'b0;
         result_q    <= '0;
         flags_q     <= '0;
      end else begin
         if (in_ready) begin
            s1Valid_q <= in_valid;
            if (in_valid) begin
               s1Payload_q <= s1Payload_d;
            end
         end
         if (s2Adv) begin
            outValid_q <= s1Valid_q;
            if (s1Valid_q) begin
               result_q <= resultD;
               flags_q  <= flagsD;
            end
         end
      end
   end

   assign out_valid = outValid_q;
   assign result    = result_q;
   assign flag_ovf  = flags_q[2];
   assign flag_unf  = flags_q[1];
   assign flag_inx  = flags_q[0];

`ifdef FPU_PACK_STICKY_FLAGS_EN
   logic [2:0] stickyFlags_q, stickyFlags_d;

   // A flag set in the same cycle as a clear survives the clear
   always_comb begin
      stickyFlags_d = (flag_clr ? 3'b000 : stickyFlags_q)
                      | ((outValid_q & out_ready) ? flags_q : 3'b000);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stickyFlags_q <= '0;
      end else begin
         stickyFlags_q <= stickyFlags_d;
      end
   end

   assign sticky_flags = stickyFlags_q;
`endif

endmodule

// File: tb/tb_fpu_norm_round_pack.sv
// Self-checking bench for fpu_norm_round_pack: directed spec vectors, backpressure, reset, random beats.
// Sticky-flag checks are compiled in when FPU_PACK_STICKY_FLAGS_EN is defined.
module tb_fpu_norm_round_pack;

   typedef struct {
      logic [27:0] sumSig;
      logic [7:0]  expBig;
      logic        signA;
      logic        signB;
      logic        aBig;
      logic        special;
      logic [31:0] specialVal;
   } beat_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [27:0] sum_sig;
   logic [7:0]  exp_big;
   logic        sign_a;
   logic        sign_b_eff;
   logic        a_is_big_mag;
   logic        in_special;
   logic [31:0] special_val;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        flag_ovf;
   logic        flag_unf;
   logic        flag_inx;
`ifdef FPU_PACK_STICKY_FLAGS_EN
   logic        flag_clr;
   logic [2:0]  sticky_flags;
   logic [2:0]  stickyModel;
`endif

   int          checks;
   int          passed;
   logic [34:0] expQ[$];
   logic [34:0] pendingWant;

   fpu_norm_round_pack dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .sum_sig      (sum_sig),
      .exp_big      (exp_big),
      .sign_a       (sign_a),
      .sign_b_eff   (sign_b_eff),
      .a_is_big_mag (a_is_big_mag),
      .in_special   (in_special),
      .special_val  (special_val),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .result       (result),
      .flag_ovf     (flag_ovf),
      .flag_unf     (flag_unf),
      .flag_inx     (flag_inx)
`ifdef FPU_PACK_STICKY_FLAGS_EN
      ,
      .flag_clr     (flag_clr),
      .sticky_flags (sticky_flags)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Value of sum_sig is sumSig * 2^(expBig-153); round that number to a single with RNE.
   function automatic logic [34:0] refModel(input beat_t b);
      longint m, q, rem, half;
      int     p, e, ulp, expField;
      logic   sgn, tiny, inexact;
      if (b.special) return {b.specialVal, 3'b000};
      if (b.sumSig == 28'd0) return {b.signA & b.signB, 31'd0, 3'b000};
      m   = longint'(b.sumSig);
      sgn = b.aBig ? b.signA : b.signB;
      p   = 0;
      for (int i = 0; i < 28; i++) if (b.sumSig[i]) p = i;
      e    = int'(b.expBig) + p - 26;
      tiny = (e < 1);
      ulp  = p - 23 + (tiny ? (1 - e) : 0);
      inexact = 1'b0;
      if (ulp <= 0) begin
         q = m << (-ulp);
      end else begin
         q    = m >> ulp;
         rem  = m & ((longint'(1) << ulp) - 1);
         half = longint'(1) << (ulp - 1);
         inexact = (rem != 0);
         if (rem > half || (rem == half && q[0])) q = q + 1;
      end
      if (q >= (longint'(1) << 24)) begin
         q = q >> 1;
         e = e + 1;
      end
      expField = tiny ? ((q >= (longint'(1) << 23)) ? 1 : 0) : e;
      if (expField >= 255) return {sgn, 8'hFF, 23'd0, 3'b101};
      return {sgn, expField[7:0], q[22:0], 1'b0, tiny & inexact, inexact};
   endfunction

   function automatic beat_t mk(input logic [27:0] s, input logic [7:0] e, input logic sa,
                                input logic sb, input logic ab);
      beat_t b;
      b.sumSig = s; b.expBig = e; b.signA = sa; b.signB = sb; b.aBig = ab;
      b.special = 1'b0; b.specialVal = 32'd0;
      return b;
   endfunction

   function automatic beat_t randBeat();
      beat_t b;
      int    sel;
      b.sumSig = 28'($urandom()) >> $urandom_range(0, 27);
      if ($urandom_range(0, 31) == 0) b.sumSig = 28'd0;
      sel = $urandom_range(0, 3);
      b.expBig = (sel == 0) ? 8'($urandom_range(1, 30)) :
                 (sel == 1) ? 8'($urandom_range(240, 254)) : 8'($urandom_range(1, 254));
      b.signA      = 1'($urandom());
      b.signB      = 1'($urandom());
      b.aBig       = 1'($urandom());
      b.special    = ($urandom_range(0, 15) == 0);
      b.specialVal = $urandom();
      return b;
   endfunction

   task automatic checkOutput(input string tag, input logic [34:0] got, input logic [34:0] want);
      checks++;
      assert (got === want) passed++;
      else $error("[TB] FAIL %s: observed %h expected %h", tag, got, want);
   endtask

   task automatic driveBeat(input beat_t b);
      sum_sig      = b.sumSig;
      exp_big      = b.expBig;
      sign_a       = b.signA;
      sign_b_eff   = b.signB;
      a_is_big_mag = b.aBig;
      in_special   = b.special;
      special_val  = b.specialVal;
      in_valid     = 1'b1;
   endtask

   // One clock from a negedge: set out_ready, sample #1 later, score transfers, wait next negedge
   task automatic tick(input int readyMode, output bit accepted);
      logic [34:0] got, want;
      bit          outXfer, haveWant;
      out_ready = (readyMode == 0) ? 1'b1 : (readyMode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
`ifdef FPU_PACK_STICKY_FLAGS_EN
      flag_clr = ($urandom_range(0, 7) == 0);
`endif
      #1;
      got      = {result, flag_ovf, flag_unf, flag_inx};
      outXfer  = out_valid && out_ready;
      haveWant = 1'b0;
      want     = '0;
      if (outXfer) begin
         if (expQ.size() == 0) begin
            checkOutput("spurious_out", 35'(out_valid), 35'd0);
         end else begin
            want     = expQ.pop_front();
            haveWant = 1'b1;
            checkOutput("result", got, want);
         end
      end
`ifdef FPU_PACK_STICKY_FLAGS_EN
      checkOutput("sticky", 35'(sticky_flags), 35'(stickyModel));
      stickyModel = (flag_clr ? 3'b000 : stickyModel) | (haveWant ? want[2:0] : 3'b000);
`endif
      accepted = in_valid && in_ready;
      if (accepted) expQ.push_back(pendingWant);
      @(negedge clk);
   endtask

   task automatic applyStimulus(input beat_t b, input logic [34:0] want, input bit useWant,
                                input int readyMode);
      bit acc;
      int waited;
      driveBeat(b);
      pendingWant = useWant ? want : refModel(b);
      acc    = 1'b0;
      waited = 0;
      while (!acc) begin
         tick(readyMode, acc);
         if (!acc && ++waited > 50) begin
            checkOutput("accept_timeout", 35'(in_ready), 35'd1);
            in_valid = 1'b0;
            acc      = 1'b1;
         end
      end
   endtask

   task automatic drain(input int maxCycles);
      bit acc;
      in_valid = 1'b0;
      for (int i = 0; i < maxCycles && expQ.size() != 0; i++) tick(0, acc);
      checkOutput("drain_left", 35'(expQ.size()), 35'd0);
   endtask

   initial begin
      beat_t b1, b2, b3, zb;
      bit    acc;
      checks = 0; passed = 0;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      sum_sig = '0; exp_big = '0; sign_a = 1'b0; sign_b_eff = 1'b0;
      a_is_big_mag = 1'b0; in_special = 1'b0; special_val = '0;
`ifdef FPU_PACK_STICKY_FLAGS_EN
      flag_clr = 1'b0; stickyModel = 3'b000;
`endif
      repeat (3) @(negedge clk);
      #1;
      checkOutput("reset_result_flags", {result, flag_ovf, flag_unf, flag_inx}, 35'd0);
      checkOutput("reset_valid_ready", 35'({out_valid, in_ready}), 35'b01);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors with hand-derived expectations
      applyStimulus(mk(28'h8000000, 8'd127, 1'b0, 1'b0, 1'b1), {32'h40000000, 3'b000}, 1'b1, 0);
      applyStimulus(mk(28'h0000008, 8'd127, 1'b0, 1'b0, 1'b1), {32'h34000000, 3'b000}, 1'b1, 0);
      applyStimulus(mk(28'h0000000, 8'd127, 1'b0, 1'b1, 1'b1), {32'h00000000, 3'b000}, 1'b1, 0);
      applyStimulus(mk(28'h0000000, 8'd127, 1'b1, 1'b1, 1'b0), {32'h80000000, 3'b000}, 1'b1, 0);
      applyStimulus(mk(28'h7FFFFFC, 8'd127, 1'b0, 1'b0, 1'b1), {32'h40000000, 3'b001}, 1'b1, 0);
      applyStimulus(mk(28'h7FFFFF4, 8'd127, 1'b0, 1'b0, 1'b1), {32'h3FFFFFFE, 3'b001}, 1'b1, 0);
      applyStimulus(mk(28'h8000000, 8'd254, 1'b0, 1'b0, 1'b1), {32'h7F800000, 3'b101}, 1'b1, 0);
      applyStimulus(mk(28'h4000000, 8'd127, 1'b0, 1'b1, 1'b0), {32'hBF800000, 3'b000}, 1'b1, 0);
      applyStimulus(mk(28'h0000005, 8'd1,   1'b0, 1'b0, 1'b1), {32'h00000001, 3'b011}, 1'b1, 0);
      zb = mk(28'h0000001, 8'd5, 1'b1, 1'b0, 1'b1);
      zb.special = 1'b1; zb.specialVal = 32'h7FC00001;
      applyStimulus(zb, {32'h7FC00001, 3'b000}, 1'b1, 0);
      drain(10);

      // Backpressure: two beats fill the pipe, the third must wait
      b1 = mk(28'h4000000, 8'd127, 1'b0, 1'b0, 1'b1);
      b2 = mk(28'h4800000, 8'd128, 1'b1, 1'b0, 1'b1);
      b3 = mk(28'h8000008, 8'd100, 1'b0, 1'b1, 1'b0);
      applyStimulus(b1, {32'h3F800000, 3'b000}, 1'b1, 2);
      applyStimulus(b2, {32'hC0100000, 3'b000}, 1'b1, 2);
      driveBeat(b3);
      out_ready = 1'b0;
      #1;
      checkOutput("bp_in_ready", 35'(in_ready), 35'd0);
      checkOutput("bp_hold", {result, flag_ovf, flag_unf, flag_inx}, expQ[0]);
      @(negedge clk);
      #1;
      checkOutput("bp_in_ready2", 35'(in_ready), 35'd0);
      checkOutput("bp_hold2", {result, flag_ovf, flag_unf, flag_inx}, expQ[0]);
      @(negedge clk);
      applyStimulus(b3, '0, 1'b0, 0);
      drain(10);

      // Reset in the middle of a stream discards in-flight beats
      applyStimulus(randBeat(), '0, 1'b0, 0);
      applyStimulus(randBeat(), '0, 1'b0, 0);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_out_valid", 35'(out_valid), 35'd0);
      expQ.delete();
      in_valid = 1'b0;
`ifdef FPU_PACK_STICKY_FLAGS_EN
      stickyModel = 3'b000;
`endif
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) tick(0, acc);
      checkOutput("rst_no_stale", 35'(out_valid), 35'd0);

      // Random traffic with random backpressure
      for (int i = 0; i < 300; i++) applyStimulus(randBeat(), '0, 1'b0, 1);
      drain(20);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
